uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side UART controller, the counterpart of the existing transmit path. It samples the asynchronous serial line RXD and frames 8N1-style characters: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity. Each received byte is presented on a held valid/ack output register that feeds the receive FIFO or the RAM writer. Framing errors and overruns are reported as one-cycle pulses.

Parameters:
DATA_WIDTH, 8, data bits per character.
CLKS_PER_BIT, 868, CLK cycles per bit period (100 MHz / 115200). Must be >= 4.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
RXD  input  1  serial line, idle high, asynchronous to CLK.
rx_ack  input  1  consumer accepts rx_data while rx_valid=1.
rx_data  output  DATA_WIDTH  last received character.
rx_valid  output  1  rx_data holds an unconsumed character.
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
rx_overrun  output  1  one-cycle pulse: character dropped because the output register was still full.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): both RXD synchroniser flops set to 1; FSM goes to IDLE; counter, bit index and shift register cleared; rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0. Asserting reset mid-frame aborts the frame with no pulses.
- RXD passes through a 2-flop synchroniser. rxd_s is the second flop. The FSM uses only rxd_s.
- HALF = CLKS_PER_BIT/2 (integer). The counter is wide enough for CLKS_PER_BIT-1. "Expire" means counter==limit-1; on expire the counter resets to 0, otherwise it increments.
- IDLE: if rxd_s=0, go to START with counter=0.
- START: limit is HALF. On expire, if rxd_s=0, go to DATA with bit_idx=0. If rxd_s=1, go to IDLE (glitch rejected, no pulse).
- DATA: limit is CLKS_PER_BIT. On expire, shift right with rxd_s entering the MSB (LSB-first assembly) and increment bit_idx. After the DATA_WIDTH-th sample, go to STOP.
- STOP: limit is CLKS_PER_BIT. On expire, act on rxd_s:
  - rxd_s=1 and (rx_valid=0 or rx_ack=1): load rx_data from the shift register, set rx_valid=1, go to IDLE.
  - rxd_s=1 and rx_valid=1 and rx_ack=0: discard the character, pulse rx_overrun for 1 cycle, keep rx_data/rx_valid unchanged, go to IDLE.
  - rxd_s=0: discard the character, pulse rx_frame_err for 1 cycle, go to BREAK.
- BREAK: stay until rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering a frame.
- Handshake:
  - rx_valid is cleared on the edge where rx_valid=1 and rx_ack=1, unless a new character loads on that same edge; the new load wins and rx_valid stays 1.
  - rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid is registered high on rising edge number 2 + HALF + (DATA_WIDTH+1)*CLKS_PER_BIT, counting the edge that first samples RXD low as edge 0. With CLKS_PER_BIT=16 and DATA_WIDTH=8 this is edge 154.
- Back-to-back frames are supported. The FSM returns to IDLE mid-stop-bit, so the next start edge is detected immediately.
- rx_busy = (state != IDLE), registered with the state.

Test Plan:
- CLKS_PER_BIT=16. Drive 0xA5 (line 0,1,0,1,0,0,1,0,1,1), each bit 16 cycles -> rx_valid rises at edge 154 with rx_data=0xA5. Pulse rx_ack -> rx_valid=0 the next cycle.
- Drive RXD low for 4 cycles, then high -> FSM returns to IDLE after START. No rx_valid, rx_frame_err or rx_overrun.
- Drive 0x3C with the stop bit low, line held low for 40 more cycles -> rx_frame_err pulses once, rx_valid stays 0, no new frame starts until RXD returns high. Then drive 0x81 -> rx_data=0x81.
- Drive 0x11 then 0x22 back-to-back with no rx_ack -> rx_data=0x11, rx_valid=1, one rx_overrun pulse at the 0x22 stop sample.
- Drive 0x11 and 0x22 back-to-back, asserting rx_ack exactly on the 0x22 stop-sample edge -> rx_data=0x22, rx_valid stays 1, no rx_overrun.
- Assert RST_N=0 mid-data of 0xFF -> all outputs 0 immediately. Release, then drive 0x5A -> rx_data=0x5A, correct latency.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side character handshake and status pulses between the UART receiver
// and its consumer (receive FIFO or RAM writer).
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  rx_frame_err;
  logic                  rx_overrun;
  logic                  rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop RXD synchroniser, start/data/stop framing FSM with mid-bit
// sampling, held valid/ack output register, frame-error and overrun pulses.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           RXD,
  uart_rx_ctrl_if.master rx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  rxd_s;
  logic                  expire;

  assign rxd_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    expire  = (state_q == StStart) ? (cnt_q == HalfLast) : (cnt_q == BitLast);

    if (valid_q && rx.rx_ack) begin
      valid_d = 1'b0;
    end

    cnt_d = expire ? '0 : cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (expire) begin
          idx_d   = '0;
          state_d = rxd_s ? StIdle : StData;
        end
      end
      StData: begin
        if (expire) begin
          shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        // Leave mid-stop-bit so a back-to-back start edge is caught right away.
        if (expire) begin
          if (rxd_s) begin
            if (!valid_q || rx.rx_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], RXD};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_overrun   = ovr_q;
  assign rx.rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed framing scenarios plus randomized
// characters and ack timing checked against a frame-level behavioural model.
module tb_uart_rx_ctrl;

  localparam int DW         = 8;
  localparam int CPB        = 16;
  localparam int FrameEdges = 10 * CPB;
  // Edge (relative to the first low sample) on which the stop bit is judged.
  localparam int StopEdge   = 2 + CPB / 2 + (DW + 1) * CPB;

  logic CLK = 1'b0;
  logic RST_N;
  logic RXD;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

  uart_rx_ctrl #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .RXD  (RXD),
    .rx   (ifc.master)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: the character the consumer should currently see.
  logic          m_valid;
  logic [DW-1:0] m_data;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Predicts one frame's outcome from the handshake rules, with an optional single ack
  // asserted on edge ack_edge of the frame (-1 = none).
  task automatic model_frame(input logic [DW-1:0] d, input logic stop, input int ack_edge,
                             output int e_v, output int e_o, output int e_f);
    logic loaded;
    logic v_before;
    loaded = 1'b0;
    e_o = -1;
    e_f = -1;
    if (ack_edge >= 0 && ack_edge < StopEdge) m_valid = 1'b0;
    v_before = m_valid;
    if (stop) begin
      if (!m_valid || ack_edge == StopEdge) begin
        m_data  = d;
        m_valid = 1'b1;
        loaded  = 1'b1;
      end else begin
        e_o = StopEdge;
      end
    end else begin
      e_f = StopEdge;
    end
    if (ack_edge > StopEdge && m_valid) m_valid = 1'b0;
    e_v = (loaded && !v_before) ? StopEdge : -1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int ack_edge,
                            output int v_edge, output int o_edge, output int o_n,
                            output int f_edge, output int f_n);
    logic [9:0] bits;
    logic       prev;
    bits   = {stop, d, 1'b0};
    v_edge = -1;
    o_edge = -1;
    f_edge = -1;
    o_n    = 0;
    f_n    = 0;
    prev   = ifc.rx_valid;
    for (int n = 0; n < FrameEdges; n++) begin
      if (n != 0 && (n % CPB) == 0) bits = bits >> 1;
      RXD        = bits[0];
      ifc.rx_ack = (n == ack_edge);
      tick();
      if (ifc.rx_valid && !prev && v_edge < 0) v_edge = n;
      prev = ifc.rx_valid;
      if (ifc.rx_overrun) begin
        o_n++;
        if (o_edge < 0) o_edge = n;
      end
      if (ifc.rx_frame_err) begin
        f_n++;
        if (f_edge < 0) f_edge = n;
      end
    end
    ifc.rx_ack = 1'b0;
  endtask

  task automatic drain();
    if (m_valid) begin
      ifc.rx_ack = 1'b1;
      tick();
      ifc.rx_ack = 1'b0;
      m_valid    = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    RST_N      = 1'b0;
    RXD        = 1'b1;
    ifc.rx_ack = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    #2;
    total_cnt++; if (ifc.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifc.rx_valid); else pass_cnt++;
    total_cnt++; if (ifc.rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", ifc.rx_data); else pass_cnt++;
    total_cnt++; if (ifc.rx_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ifc.rx_frame_err); else pass_cnt++;
    total_cnt++; if (ifc.rx_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ifc.rx_overrun); else pass_cnt++;
    total_cnt++; if (ifc.rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifc.rx_busy); else pass_cnt++;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int v, o, on, f, fn, ev, eo, ef;
    model_frame(8'hA5, 1'b1, -1, ev, eo, ef);
    send_frame(8'hA5, 1'b1, -1, v, o, on, f, fn);
    total_cnt++; if (v !== ev) $display("FAIL basic_latency: got edge %0d want %0d", v, ev); else pass_cnt++;
    total_cnt++; if (ifc.rx_data !== m_data) $display("FAIL basic_data: got %h want %h", ifc.rx_data, m_data); else pass_cnt++;
    total_cnt++; if (on !== 0 || fn !== 0) $display("FAIL basic_pulses: got ovr %0d ferr %0d want 0 0", on, fn); else pass_cnt++;
    ifc.rx_ack = 1'b1;
    tick();
    ifc.rx_ack = 1'b0;
    m_valid    = 1'b0;
    total_cnt++; if (ifc.rx_valid !== m_valid) $display("FAIL basic_ack_clear: got %b want %b", ifc.rx_valid, m_valid); else pass_cnt++;
    ifc.rx_ack = 1'b1;
    tick();
    ifc.rx_ack = 1'b0;
    total_cnt++; if (ifc.rx_valid !== 1'b0 || ifc.rx_data !== 8'hA5) $display("FAIL basic_idle_ack: got valid %b data %h want 0 a5", ifc.rx_valid, ifc.rx_data); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int busy_seen, pulses, rises;
    busy_seen = 0;
    pulses    = 0;
    rises     = 0;
    RXD = 1'b0;
    repeat (4) tick();
    RXD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifc.rx_busy) busy_seen++;
      if (ifc.rx_frame_err || ifc.rx_overrun) pulses++;
      if (ifc.rx_valid) rises++;
    end
    total_cnt++; if (busy_seen == 0) $display("FAIL glitch_start_seen: got busy cycles %0d want >0", busy_seen); else pass_cnt++;
    total_cnt++; if (ifc.rx_busy !== 1'b0) $display("FAIL glitch_idle: got busy %b want 0", ifc.rx_busy); else pass_cnt++;
    total_cnt++; if (pulses !== 0 || rises !== 0) $display("FAIL glitch_quiet: got pulses %0d valid %0d want 0 0", pulses, rises); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int v, o, on, f, fn, ev, eo, ef, idle_cycles, extra;
    drain();
    model_frame(8'h3C, 1'b0, -1, ev, eo, ef);
    send_frame(8'h3C, 1'b0, -1, v, o, on, f, fn);
    total_cnt++; if (f !== ef || fn !== 1) $display("FAIL ferr_pulse: got edge %0d count %0d want %0d 1", f, fn, ef); else pass_cnt++;
    total_cnt++; if (ifc.rx_valid !== m_valid || v !== ev) $display("FAIL ferr_no_valid: got valid %b edge %0d want %b %0d", ifc.rx_valid, v, m_valid, ev); else pass_cnt++;
    idle_cycles = 0;
    extra       = 0;
    RXD = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!ifc.rx_busy) idle_cycles++;
      if (ifc.rx_frame_err || ifc.rx_valid) extra++;
    end
    total_cnt++; if (idle_cycles !== 0 || extra !== 0) $display("FAIL ferr_break_hold: got idle %0d extra %0d want 0 0", idle_cycles, extra); else pass_cnt++;
    RXD = 1'b1;
    repeat (4) tick();
    total_cnt++; if (ifc.rx_busy !== 1'b0) $display("FAIL ferr_break_exit: got busy %b want 0", ifc.rx_busy); else pass_cnt++;
    model_frame(8'h81, 1'b1, -1, ev, eo, ef);
    send_frame(8'h81, 1'b1, -1, v, o, on, f, fn);
    total_cnt++; if (ifc.rx_data !== m_data || v !== ev) $display("FAIL ferr_recover: got data %h edge %0d want %h %0d", ifc.rx_data, v, m_data, ev); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v, o, on, f, fn, ev, eo, ef;
    drain();
    model_frame(8'h11, 1'b1, -1, ev, eo, ef);
    send_frame(8'h11, 1'b1, -1, v, o, on, f, fn);
    model_frame(8'h22, 1'b1, -1, ev, eo, ef);
    send_frame(8'h22, 1'b1, -1, v, o, on, f, fn);
    total_cnt++; if (o !== eo || on !== 1) $display("FAIL b2b_overrun: got edge %0d count %0d want %0d 1", o, on, eo); else pass_cnt++;
    total_cnt++; if (ifc.rx_data !== m_data || ifc.rx_valid !== m_valid) $display("FAIL b2b_keep: got data %h valid %b want %h %b", ifc.rx_data, ifc.rx_valid, m_data, m_valid); else pass_cnt++;
    drain();
    model_frame(8'h11, 1'b1, -1, ev, eo, ef);
    send_frame(8'h11, 1'b1, -1, v, o, on, f, fn);
    model_frame(8'h22, 1'b1, StopEdge, ev, eo, ef);
    send_frame(8'h22, 1'b1, StopEdge, v, o, on, f, fn);
    total_cnt++; if (on !== 0) $display("FAIL b2b_ack_no_ovr: got count %0d want 0", on); else pass_cnt++;
    total_cnt++; if (ifc.rx_data !== m_data || ifc.rx_valid !== m_valid) $display("FAIL b2b_ack_load: got data %h valid %b want %h %b", ifc.rx_data, ifc.rx_valid, m_data, m_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    int v, o, on, f, fn, ev, eo, ef, ack, gap, sel;
    logic [DW-1:0] d;
    for (int k = 0; k < 10; k++) begin
      d   = DW'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       ack = -1;
        1:       ack = StopEdge;
        default: ack = int'($urandom_range(0, FrameEdges - 1));
      endcase
      gap = int'($urandom_range(0, 3)) == 0 ? 0 : int'($urandom_range(1, 25));
      RXD = 1'b1;
      for (int g = 0; g < gap; g++) tick();
      model_frame(d, 1'b1, ack, ev, eo, ef);
      send_frame(d, 1'b1, ack, v, o, on, f, fn);
      total_cnt++; if (v !== ev) $display("FAIL rand%0d_valid_edge: got %0d want %0d", k, v, ev); else pass_cnt++;
      total_cnt++; if (o !== eo || on !== (eo < 0 ? 0 : 1)) $display("FAIL rand%0d_overrun: got edge %0d count %0d want %0d", k, o, on, eo); else pass_cnt++;
      total_cnt++; if (fn !== 0) $display("FAIL rand%0d_ferr: got %0d want 0", k, fn); else pass_cnt++;
      total_cnt++; if (ifc.rx_valid !== m_valid || ifc.rx_data !== m_data) $display("FAIL rand%0d_out: got valid %b data %h want %b %h", k, ifc.rx_valid, ifc.rx_data, m_valid, m_data); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int v, o, on, f, fn, ev, eo, ef;
    logic [9:0] bits;
    drain();
    model_frame(8'h96, 1'b1, -1, ev, eo, ef);
    send_frame(8'h96, 1'b1, -1, v, o, on, f, fn);
    bits = {1'b1, 8'hFF, 1'b0};
    for (int n = 0; n < 70; n++) begin
      if (n != 0 && (n % CPB) == 0) bits = bits >> 1;
      RXD = bits[0];
      tick();
    end
    total_cnt++; if (ifc.rx_busy !== 1'b1 || ifc.rx_valid !== 1'b1) $display("FAIL rstmid_pre: got busy %b valid %b want 1 1", ifc.rx_busy, ifc.rx_valid); else pass_cnt++;
    RST_N = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = '0;
    total_cnt++; if (ifc.rx_valid !== m_valid || ifc.rx_data !== m_data) $display("FAIL rstmid_out: got valid %b data %h want 0 00", ifc.rx_valid, ifc.rx_data); else pass_cnt++;
    total_cnt++; if (ifc.rx_busy !== 1'b0 || ifc.rx_frame_err !== 1'b0 || ifc.rx_overrun !== 1'b0) $display("FAIL rstmid_status: got busy %b ferr %b ovr %b want 0 0 0", ifc.rx_busy, ifc.rx_frame_err, ifc.rx_overrun); else pass_cnt++;
    RXD = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    model_frame(8'h5A, 1'b1, -1, ev, eo, ef);
    send_frame(8'h5A, 1'b1, -1, v, o, on, f, fn);
    total_cnt++; if (v !== ev || ifc.rx_data !== m_data) $display("FAIL rstmid_after: got edge %0d data %h want %0d %h", v, ifc.rx_data, ev, m_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
